// File: rtl/pic_irq_control.sv
// pic_irq_control: 8259-style interrupt path downstream of the mask block.
// Latches requests into IRR, resolves rotating priority against ISR, raises
// INT, runs the two-pulse INTA handshake that returns the vector, and
// services EOI commands.
//
// state  | meaning
// S_IDLE | waiting for first INTA falling edge, INT may be asserted
// S_ACK1 | first INTA seen, winner latched, waiting for second INTA edge
module pic_irq_control #(
  parameter int NUM_IR = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_IR-1:0] i_ir,
  input  logic [NUM_IR-1:0] i_imr,
  input  logic              i_ltim,
  input  logic              i_aeoi,
  input  logic [4:0]        i_icw2_t,
  input  logic              i_inta_n,
  input  logic              i_eoi_valid,
  input  logic              i_eoi_specific,
  input  logic [2:0]        i_eoi_level,
  input  logic              i_rotate,
  output logic              o_int,
  output logic [7:0]        o_vec,
  output logic              o_vec_valid,
  output logic [NUM_IR-1:0] o_irr,
  output logic [NUM_IR-1:0] o_isr
);

  typedef enum logic {S_IDLE, S_ACK1} state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_irr, r_isr, r_ir_d, r_blk;
  logic [2:0]  r_lp, r_id;
  logic        r_spur, r_inta_d, r_int, r_vec_valid;
  logic [7:0]  r_vec;

  logic [7:0]  w_cand, w_ir_rise, w_irr_next, w_blk_next;
  logic [3:0]  w_cand_top, w_isr_top;
  logic [2:0]  w_cand_rank, w_isr_rank, w_take_id, w_eoi_lvl;
  logic        w_elig, w_inta_edge, w_id_load, w_vec_load, w_eoi_hit;
  logic [7:0]  w_ack_set, w_aeoi_clr, w_eoi_clr;

  // Highest-priority set bit of v; priority starts at lp+1 and wraps.
  // Returns {found, id}. Later iterations are higher priority and override.
  function automatic logic [3:0] f_top(input logic [7:0] v, input logic [2:0] lp);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = lp + 3'(k + 1);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Priority resolution: rank 0 is the highest priority level.
  always_comb begin
    w_cand      = r_irr & ~i_imr;
    w_cand_top  = f_top(w_cand, r_lp);
    w_isr_top   = f_top(r_isr, r_lp);
    w_cand_rank = w_cand_top[2:0] - r_lp - 3'd1;
    w_isr_rank  = w_isr_top[2:0] - r_lp - 3'd1;
    w_elig      = w_cand_top[3] && (!w_isr_top[3] || (w_cand_rank < w_isr_rank));
    w_inta_edge = r_inta_d & ~i_inta_n;
    w_take_id   = w_elig ? w_cand_top[2:0] : 3'd7;
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM next-state logic: each INTA falling edge advances the handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_inta_edge) w_state_next = S_ACK1;
      S_ACK1:  if (w_inta_edge) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs: acknowledge set on first edge, vector load / AEOI on second.
  always_comb begin
    w_ack_set  = 8'd0;
    w_aeoi_clr = 8'd0;
    w_id_load  = 1'b0;
    w_vec_load = 1'b0;
    case (r_state)
      S_IDLE: if (w_inta_edge) begin
        w_id_load = 1'b1;
        if (w_elig) w_ack_set = 8'd1 << w_cand_top[2:0];
      end
      S_ACK1: if (w_inta_edge) begin
        w_vec_load = 1'b1;
        if (i_aeoi && !r_spur) w_aeoi_clr = 8'd1 << r_id;
      end
      default: ;
    endcase
  end

  // EOI decode works on the pre-edge ISR; an empty target is a no-op.
  always_comb begin
    w_eoi_hit = 1'b0;
    w_eoi_lvl = 3'd0;
    if (i_eoi_valid) begin
      if (i_eoi_specific) begin
        w_eoi_hit = r_isr[i_eoi_level];
        w_eoi_lvl = i_eoi_level;
      end else begin
        w_eoi_hit = w_isr_top[3];
        w_eoi_lvl = w_isr_top[2:0];
      end
    end
    w_eoi_clr = w_eoi_hit ? (8'd1 << w_eoi_lvl) : 8'd0;
  end

  // IRR update; in level mode an acked line stays blocked until it drops.
  always_comb begin
    w_ir_rise  = i_ir & ~r_ir_d;
    w_blk_next = (r_blk | w_ack_set) & i_ir;
    if (i_ltim) w_irr_next = i_ir & ~(r_blk | w_ack_set);
    else        w_irr_next = (r_irr | w_ir_rise) & i_ir & ~w_ack_set;
  end

  // Datapath registers: IRR/ISR, priority pointer, latched id, vector, INT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irr       <= 8'd0;
      r_isr       <= 8'd0;
      r_ir_d      <= 8'd0;
      r_blk       <= 8'd0;
      r_lp        <= 3'd7;
      r_id        <= 3'd0;
      r_spur      <= 1'b0;
      r_inta_d    <= 1'b1;
      r_int       <= 1'b0;
      r_vec       <= 8'd0;
      r_vec_valid <= 1'b0;
    end else begin
      r_ir_d      <= i_ir;
      r_inta_d    <= i_inta_n;
      r_irr       <= w_irr_next;
      r_blk       <= w_blk_next;
      r_isr       <= (r_isr & ~w_eoi_clr & ~w_aeoi_clr) | w_ack_set;
      if (w_eoi_hit && i_rotate) r_lp <= w_eoi_lvl;
      if (w_id_load) begin
        r_id   <= w_take_id;
        r_spur <= !w_elig;
      end
      r_vec_valid <= w_vec_load;
      if (w_vec_load) r_vec <= {i_icw2_t, r_id};
      r_int       <= (w_state_next == S_IDLE) && w_elig;
    end
  end

  assign o_int       = r_int;
  assign o_vec       = r_vec;
  assign o_vec_valid = r_vec_valid;
  assign o_irr       = r_irr;
  assign o_isr       = r_isr;

endmodule

// File: tb/tb_pic_irq_control.sv
// Directed bench for pic_irq_control: edge/level requests, masking, nesting,
// spurious acknowledge, rotating EOI, AEOI and asynchronous reset mid-handshake.
module tb_pic_irq_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ir, imr;
  logic       ltim, aeoi;
  logic [4:0] icw2_t;
  logic       inta_n, eoi_valid, eoi_specific, rotate;
  logic [2:0] eoi_level;
  logic       int_o, vec_valid;
  logic [7:0] vec, irr, isr;

  int total = 0;
  int bad   = 0;

  pic_irq_control #(.NUM_IR(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ir(ir), .i_imr(imr), .i_ltim(ltim),
    .i_aeoi(aeoi), .i_icw2_t(icw2_t), .i_inta_n(inta_n),
    .i_eoi_valid(eoi_valid), .i_eoi_specific(eoi_specific),
    .i_eoi_level(eoi_level), .i_rotate(rotate),
    .o_int(int_o), .o_vec(vec), .o_vec_valid(vec_valid),
    .o_irr(irr), .o_isr(isr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic inta_pair();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl, input logic rot);
    eoi_valid = 1'b1; eoi_specific = spec; eoi_level = lvl; rotate = rot;
    tick();
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0; rotate = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ir = 8'h00; imr = 8'h00; ltim = 1'b0; aeoi = 1'b0;
    icw2_t = 5'h08; inta_n = 1'b1; eoi_valid = 1'b0; eoi_specific = 1'b0;
    eoi_level = 3'd0; rotate = 1'b0;
    tick(); tick();
    chk("rst_irr", irr, 8'h00);
    chk("rst_isr", isr, 8'h00);
    chk("rst_int", {7'd0, int_o}, 8'h00);
    chk("rst_vec", vec, 8'h00);
    chk("rst_vv", {7'd0, vec_valid}, 8'h00);
    rst_n = 1'b1;
    tick();

    // basic edge request on IR2
    ir = 8'h04; tick();
    chk("t1_irr", irr, 8'h04);
    chk("t1_int_lat", {7'd0, int_o}, 8'h00);
    tick();
    chk("t1_int", {7'd0, int_o}, 8'h01);
    inta_n = 1'b0; tick();
    chk("t1_ack_isr", isr, 8'h04);
    chk("t1_ack_irr", irr, 8'h00);
    chk("t1_ack_int", {7'd0, int_o}, 8'h00);
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    chk("t1_vec", vec, 8'h42);
    chk("t1_vv", {7'd0, vec_valid}, 8'h01);
    inta_n = 1'b1; tick();
    chk("t1_vv_drop", {7'd0, vec_valid}, 8'h00);
    chk("t1_vec_hold", vec, 8'h42);
    chk("t1_int_end", {7'd0, int_o}, 8'h00);

    // masked IR0 with IR7
    eoi(1'b0, 3'd0, 1'b0);
    chk("t2_eoi_isr", isr, 8'h00);
    ir = 8'h81; imr = 8'h01; tick();
    chk("t2_irr", irr, 8'h81);
    tick();
    chk("t2_int", {7'd0, int_o}, 8'h01);
    inta_pair();
    chk("t2_vec", vec, 8'h47);
    chk("t2_isr", isr, 8'h80);
    chk("t2_irr_keep", irr, 8'h01);
    ir = 8'h00; imr = 8'h00;
    eoi(1'b0, 3'd0, 1'b0);
    tick();
    chk("t2_clean_isr", isr, 8'h00);
    chk("t2_clean_irr", irr, 8'h00);
    chk("t2_clean_int", {7'd0, int_o}, 8'h00);

    // fully nested: IR3 blocked by IR2 in service, IR1 allowed
    ir = 8'h04; tick(); tick();
    inta_pair();
    chk("t3_isr", isr, 8'h04);
    ir = 8'h08; tick();
    chk("t3_irr3", irr, 8'h08);
    tick();
    chk("t3_int_blk", {7'd0, int_o}, 8'h00);
    ir = 8'h0A; tick(); tick();
    chk("t3_int_nest", {7'd0, int_o}, 8'h01);
    inta_pair();
    chk("t3_vec", vec, 8'h41);
    chk("t3_isr2", isr, 8'h06);
    chk("t3_irr", irr, 8'h08);

    // non-specific EOI with rotate: IR1 cleared, LP=1, IR2 now top
    eoi(1'b0, 3'd0, 1'b1);
    chk("t5_isr", isr, 8'h04);
    ir = 8'h0B; tick();
    chk("t5_irr", irr, 8'h09);
    tick();
    chk("t5_int_blk", {7'd0, int_o}, 8'h00);
    eoi(1'b0, 3'd0, 1'b0);
    chk("t5_isr_clr", isr, 8'h00);
    tick();
    chk("t5_int", {7'd0, int_o}, 8'h01);
    inta_pair();
    chk("t5_vec_rot", vec, 8'h43);
    chk("t5_isr3", isr, 8'h08);
    chk("t5_irr0", irr, 8'h01);
    ir = 8'h00;
    eoi(1'b1, 3'd3, 1'b0);
    tick();
    chk("t5_clean_isr", isr, 8'h00);
    chk("t5_clean_irr", irr, 8'h00);

    // spurious: IR5 pulse gone before first INTA
    icw2_t = 5'h10;
    ir = 8'h20; tick(); tick();
    chk("t4_int", {7'd0, int_o}, 8'h01);
    ir = 8'h00; tick();
    chk("t4_irr_drop", irr, 8'h00);
    inta_n = 1'b0; tick();
    chk("t4_ack_int", {7'd0, int_o}, 8'h00);
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    chk("t4_vec", vec, 8'h87);
    chk("t4_vv", {7'd0, vec_valid}, 8'h01);
    chk("t4_isr", isr, 8'h00);
    inta_n = 1'b1; tick();

    // AEOI, level triggered IR6
    aeoi = 1'b1; ltim = 1'b1;
    ir = 8'h40; tick();
    chk("t6_irr", irr, 8'h40);
    tick();
    chk("t6_int", {7'd0, int_o}, 8'h01);
    inta_pair();
    chk("t6_vec", vec, 8'h86);
    chk("t6_isr_aeoi", isr, 8'h00);
    chk("t6_irr_blk", irr, 8'h00);
    tick();
    chk("t6_int_blk", {7'd0, int_o}, 8'h00);
    ir = 8'h00; tick();
    ir = 8'h40; tick();
    chk("t6_irr_re", irr, 8'h40);
    tick();
    chk("t6_int_re", {7'd0, int_o}, 8'h01);
    inta_n = 1'b0; tick();
    chk("t6_ack1_isr", isr, 8'h40);
    rst_n = 1'b0; #1;
    chk("t6_rst_isr", isr, 8'h00);
    chk("t6_rst_irr", irr, 8'h00);
    chk("t6_rst_int", {7'd0, int_o}, 8'h00);
    chk("t6_rst_vec", vec, 8'h00);
    chk("t6_rst_vv", {7'd0, vec_valid}, 8'h00);
    inta_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t6_post_vv", {7'd0, vec_valid}, 8'h00);
    chk("t6_post_vec", vec, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
